csa_seq_accum: RTL and testbench
================================

Name: csa_seq_accum

Overview:
- Sequential multi-operand adder: receives NOPS unsigned operands one per handshake, keeps the running total in carry-save form (a sum vector plus a carry vector), then turns that into a binary total with a chunked carry-propagate pass.
- It is the streaming, receiving-end counterpart of the team's combinational 10-operand carry-save adder tree. It serves datapaths that deliver operands serially instead of in parallel.
- The result leaves through a valid/ready output.

Parameters:
- W, 8, operand width in bits.
- NOPS, 10, number of operands per sum (>=2).
- SW, 16, width of the accumulator and result. Must satisfy SW >= W + clog2(NOPS) and SW % CHUNK == 0.
- CHUNK, 4, number of bits resolved per cycle in the carry-propagate pass.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds an operand.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  unsigned operand.
- out_valid  output  1  out_sum holds a completed total.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  SW  binary total of the last NOPS operands, modulo 2^SW.
- busy  output  1  high in RESOLVE and DONE.

Behaviour:
- Reset (clk edge with rst=1): state=ACCUM, count=0, sum_r=0, carry_r=0, out_sum=0, out_valid=0, in_ready=1, busy=0. rst takes priority over every other event, in every state, including mid-RESOLVE and DONE; any partial result is discarded.
- State ACCUM:
  - in_ready=1.
  - On an edge where in_valid&&in_ready, the block does a 3:2 compression of (sum_r, carry_r, zero-extended in_data): sum_r <= s^c^d; carry_r <= ((s&c)|(s&d)|(c&d))<<1, truncated to SW bits. carry_r is stored already weighted, so bit0 is always 0.
  - count increments on each accept. No accept means no change; gaps in in_valid are allowed.
  - On the edge that accepts operand number NOPS: count <= 0, and the next state is RESOLVE.
- State RESOLVE:
  - in_ready=0.
  - Each edge adds chunk i of sum_r and chunk i of carry_r, plus a 1-bit carry flop (cleared on entry), and writes the CHUNK result bits into the result register, for i = 0 .. SW/CHUNK-1, LSB chunk first.
  - The final carry-out is dropped (arithmetic is modulo 2^SW).
  - The last chunk edge sets out_valid=1 and moves to DONE.
  - RESOLVE lasts exactly SW/CHUNK edges; in_data is ignored.
- Latency: if the last operand is accepted on edge k, out_valid is first high after edge k+SW/CHUNK (k+4 with default parameters).
- State DONE:
  - out_valid=1, in_ready=0. out_sum is stable until the handshake completes.
  - On an edge with out_ready=1: out_valid <= 0, sum_r <= 0, carry_r <= 0, next state ACCUM.
  - out_sum keeps its last value after the handshake.
  - out_ready held low stalls the block indefinitely with no loss of data.
- out_ready is ignored outside DONE. in_valid is ignored outside ACCUM, and those operands are not counted.
- Overflow: not possible while the parameter constraint holds. If the constraint is violated, the result wraps modulo 2^SW with no flag.
- All outputs are registered or decoded directly from state; there is no combinational path from an input to an output.

Test Plan:
- After reset, stream operands 11,2,13,4,5,6,7,8,9,10 back-to-back -> in_ready drops after the 10th accept; out_valid rises exactly 4 edges later; out_sum=75.
- Next frame 3,14,5,6,7,8,19,10,0,0 with in_valid deasserted for 3 random cycles mid-stream -> out_sum=72, and gap cycles do not advance count.
- Ten operands of 255 -> out_sum=2550 (0x09F6). This checks carry propagation across all chunk boundaries.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid and out_sum stay stable, in_ready=0, and in_valid pulses are not counted. Then assert out_ready -> one-cycle handshake, return to ACCUM, and the next frame of all 1s gives out_sum=10.
- Assert rst after 5 operands, and separately during the 2nd RESOLVE cycle -> all outputs return to reset values on the next edge; a following 10-operand frame of value 1 gives out_sum=10, uncorrupted by the earlier partial state.
- Parameter variant W=4, NOPS=3, SW=8, CHUNK=2: operands 15,15,15 -> out_sum=45, out_valid rises 4 edges after the last accept.

Source files
------------

// File: rtl/csa_seq_accum.sv
// Streaming multi-operand adder: folds NOPS operands into a carry-save running total,
// then resolves it to binary CHUNK bits per cycle and presents it on a valid/ready port.
module csa_seq_accum #(
    parameter int W     = 8,
    parameter int NOPS  = 10,
    parameter int SW    = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          busy
);

    localparam int NCH = SW / CHUNK;
    localparam int CW  = (NOPS > 1) ? $clog2(NOPS) : 1;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_OP = CW'(NOPS - 1);
    localparam logic [IW-1:0] LAST_CH = IW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [IW-1:0]   idx;
    logic            cy;
    logic [SW-1:0]   sum_r;
    logic [SW-1:0]   carry_r;
    logic [SW-1:0]   res_r;
    logic [SW-1:0]   operand;
    logic [SW-1:0]   csa_s;
    logic [SW-1:0]   csa_c;
    logic [CHUNK:0]  chunk_sum;
    logic            accept;
    logic            last_op;
    logic            last_chunk;

    // 3:2 compressor; the carry vector is stored pre-shifted so bit 0 is always zero.
    assign operand = SW'(in_data);
    assign csa_s   = sum_r ^ carry_r ^ operand;
    assign csa_c   = ((sum_r & carry_r) | (sum_r & operand) | (carry_r & operand)) << 1;

    assign accept     = in_valid && (state == ST_ACCUM);
    assign last_op    = accept && (count == LAST_OP);
    assign last_chunk = (state == ST_RESOLVE) && (idx == LAST_CH);

    assign chunk_sum = {1'b0, sum_r[int'(idx) * CHUNK +: CHUNK]}
                     + {1'b0, carry_r[int'(idx) * CHUNK +: CHUNK]}
                     + (CHUNK + 1)'(cy);

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_ACCUM);
    assign out_sum   = res_r;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:   if (last_op)    state_nxt = ST_RESOLVE;
            ST_RESOLVE: if (last_chunk) state_nxt = ST_DONE;
            ST_DONE:    if (out_ready)  state_nxt = ST_ACCUM;
            default:                    state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            idx     <= '0;
            cy      <= 1'b0;
            sum_r   <= '0;
            carry_r <= '0;
            res_r   <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        sum_r   <= csa_s;
                        carry_r <= csa_c;
                        count   <= last_op ? '0 : count + 1'b1;
                        idx     <= '0;
                        cy      <= 1'b0;
                    end
                end
                ST_RESOLVE: begin
                    // Final carry-out of the top chunk is dropped: result is modulo 2^SW.
                    res_r[int'(idx) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    cy  <= chunk_sum[CHUNK];
                    idx <= last_chunk ? '0 : idx + 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        sum_r   <= '0;
                        carry_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_accum.sv
// Bench for csa_seq_accum: integer-arithmetic frame model checked every cycle, plus
// literal expectations for each directed frame, on a default and a small-parameter DUT.
module tb_csa_seq_accum;

    localparam int W = 8, NOPS = 10, SW = 16, CHUNK = 4;
    localparam int VW = 4, VN = 3, VSW = 8, VCH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, busy;
    logic [SW-1:0] out_sum;

    logic           v_in_valid = 1'b0;
    logic           v_out_ready = 1'b0;
    logic [VW-1:0]  v_in_data = '0;
    logic           v_in_ready, v_out_valid, v_busy;
    logic [VSW-1:0] v_out_sum;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    csa_seq_accum #(.W(W), .NOPS(NOPS), .SW(SW), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy));

    csa_seq_accum #(.W(VW), .NOPS(VN), .SW(VSW), .CHUNK(VCH)) dut_v (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready), .in_data(v_in_data),
        .out_valid(v_out_valid), .out_ready(v_out_ready), .out_sum(v_out_sum), .busy(v_busy));

    // Frame-level model: 0 = taking operands, 1 = resolving, 2 = result offered.
    typedef struct {
        int     mode;
        int     cnt;
        longint total;
        int     wait_left;
        longint last_res;
    } mdl_t;

    mdl_t m0 = '{0, 0, 0, 0, 0};
    mdl_t m1 = '{0, 0, 0, 0, 0};

    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit iv, input longint d,
                                      input bit ordy, input int nops, input int nch, input int sw);
        mdl_t n = m;
        if (r) begin
            n = '{0, 0, 0, 0, 0};
        end else begin
            case (m.mode)
                0: if (iv) begin
                    n.total = m.total + d;
                    n.cnt   = m.cnt + 1;
                    if (n.cnt == nops) begin
                        n.mode = 1;
                        n.cnt = 0;
                        n.wait_left = nch;
                    end
                end
                1: begin
                    n.wait_left = m.wait_left - 1;
                    if (n.wait_left == 0) begin
                        n.mode = 2;
                        n.last_res = n.total % (longint'(1) << sw);
                        n.total = 0;
                    end
                end
                default: if (ordy) n.mode = 0;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = mdl_step(m0, rst, in_valid, longint'(in_data), out_ready, NOPS, SW / CHUNK, SW);
        m1 = mdl_step(m1, rst, v_in_valid, longint'(v_in_data), v_out_ready, VN, VSW / VCH, VSW);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl in_ready", 64'(in_ready), 64'(m0.mode == 0));
            check("mdl out_valid", 64'(out_valid), 64'(m0.mode == 2));
            check("mdl busy", 64'(busy), 64'(m0.mode != 0));
            if (m0.mode != 1) check("mdl out_sum", 64'(out_sum), 64'(m0.last_res));
            check("mdl v in_ready", 64'(v_in_ready), 64'(m1.mode == 0));
            check("mdl v out_valid", 64'(v_out_valid), 64'(m1.mode == 2));
            check("mdl v busy", 64'(v_busy), 64'(m1.mode != 0));
            if (m1.mode != 1) check("mdl v out_sum", 64'(v_out_sum), 64'(m1.last_res));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = W'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int exp);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(SW / CHUNK));
        check({name, " sum"}, 64'(out_sum), 64'(exp));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " valid after hs"}, 64'(out_valid), 64'd0);
        check({name, " ready after hs"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        check({name, " out_valid"}, 64'(out_valid), 64'd0);
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " out_sum"}, 64'(out_sum), 64'd0);
    endtask

    int f1[10] = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
    int f2[10] = '{3, 14, 5, 6, 7, 8, 19, 10, 0, 0};

    initial begin
        int gap_pos;
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("reset");

        // Frame 1: back-to-back operands.
        for (int i = 0; i < 10; i++) begin
            check("f1 ready before accept", 64'(in_ready), 64'd1);
            send(f1[i]);
        end
        check("f1 ready after 10th", 64'(in_ready), 64'd0);
        wait_done("f1", 75);
        handshake("f1");

        // Frame 2: a 3-cycle gap with junk data somewhere mid-stream.
        gap_pos = $urandom_range(1, 8);
        for (int i = 0; i < 10; i++) begin
            if (i == gap_pos) begin
                in_data = 8'hAA;
                idle(3);
            end
            send(f2[i]);
        end
        wait_done("f2", 72);
        handshake("f2");

        // Frame 3: all-ones operands ripple carries across every chunk, then a long stall.
        for (int i = 0; i < 10; i++) send(255);
        wait_done("f3", 2550);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_data  = 8'd7;
            @(negedge clk);
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall out_sum", 64'(out_sum), 64'd2550);
            check("stall in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handshake("f3");
        check("f3 sum held", 64'(out_sum), 64'd2550);
        for (int i = 0; i < 10; i++) send(1);
        wait_done("f4", 10);
        handshake("f4");

        // Reset after five operands.
        for (int i = 0; i < 5; i++) send(9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst mid-accum");
        for (int i = 0; i < 10; i++) send(1);
        wait_done("f5", 10);
        handshake("f5");

        // Reset on the second RESOLVE edge.
        for (int i = 0; i < 10; i++) send(200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst mid-resolve");
        for (int i = 0; i < 10; i++) send(1);
        wait_done("f6", 10);
        handshake("f6");

        // Small-parameter instance: W=4, NOPS=3, SW=8, CHUNK=2.
        for (int i = 0; i < 3; i++) begin
            v_in_valid = 1'b1;
            v_in_data  = 4'd15;
            @(negedge clk);
        end
        v_in_valid = 1'b0;
        n = 0;
        while (!v_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("v latency", 64'(n), 64'd4);
        check("v sum", 64'(v_out_sum), 64'd45);
        v_out_ready = 1'b1;
        @(negedge clk);
        v_out_ready = 1'b0;
        check("v valid after hs", 64'(v_out_valid), 64'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
